// File: rtl/seq_mult.sv
// Sequential shift-add multiplier: one partial-product row per clock, unsigned or
// two's-complement signed, with valid/ready handshakes on operands and product.
module seq_mult #(
  parameter int WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               sgn,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] z,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] x_reg;
  logic signed [WIDTH-1:0] y_reg;
  logic            sgn_reg;
  logic [PW-1:0]   acc;
  logic            rdy_q;
  logic            accept;
  logic            last_iter;

  // One shift-add step; the top row of a signed multiplier carries weight -2^(W-1),
  // so it is subtracted instead of added.
  function automatic logic [PW-1:0] pp_step(
    input logic [PW-1:0]           p,
    input logic                    xbit,
    input logic signed [WIDTH-1:0] yv,
    input logic                    s,
    input logic [CW-1:0]           sh,
    input logic                    last
  );
    logic [PW-1:0] ext;
    logic [PW-1:0] addend;
    ext    = s ? {{WIDTH{yv[WIDTH-1]}}, yv} : {{WIDTH{1'b0}}, yv};
    addend = ext << sh;
    if (!xbit)
      pp_step = p;
    else if (s && last)
      pp_step = p - addend;
    else
      pp_step = p + addend;
  endfunction

  assign accept    = in_valid && rdy_q;
  assign last_iter = (cnt == CW'(WIDTH - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (last_iter) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rdy_q <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
    end else begin
      state <= state_nxt;
      rdy_q <= (state_nxt == IDLE);
      if (state == IDLE && accept) begin
        cnt <= '0;
        acc <= '0;
      end else if (state == BUSY) begin
        cnt <= cnt + CW'(1);
        acc <= pp_step(acc, x_reg[cnt], y_reg, sgn_reg, cnt, last_iter);
      end
    end
  end

  // Operand capture: only at accept, so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (state == IDLE && accept) begin
      x_reg   <= x;
      y_reg   <= y;
      sgn_reg <= sgn;
    end
  end

  assign in_ready  = rdy_q;
  assign busy      = (state == BUSY);
  assign out_valid = (state == DONE);
  assign z         = acc;

endmodule

// File: doc/seq_mult.md
# seq_mult

Parameterised sequential multiplier for the arithmetic datapath. It computes the full-width product of two WIDTH-bit operands in either unsigned or two's-complement signed mode. It uses one shift-add iteration per clock, with a valid/ready handshake on both sides. The area per bit is lower than the combinational array multiplier. Signed mode subtracts the final partial-product row, so it needs no pre- or post-negation.

## Interface
- WIDTH, 6: operand width in bits; must be ≥ 2. The product is 2*WIDTH bits.
- clk  input  1  sole clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  operands and mode are presented.
- in_ready  output  1  block can accept an operation.
- x  input  WIDTH  multiplier operand.
- y  input  WIDTH  multiplicand operand.
- sgn  input  1  1 = two's-complement signed, 0 = unsigned.
- out_valid  output  1  z holds a completed product.
- out_ready  input  1  consumer accepts z.
- z  output  2*WIDTH  product, modulo 2^(2*WIDTH).
- busy  output  1  high in BUSY state.

## Operation
- States:
  - IDLE: in_ready=1. Moves to BUSY on accept (in_valid && in_ready).
  - BUSY: runs iterations i = 0..WIDTH-1, one per edge. Moves to DONE after iteration WIDTH-1.
  - DONE: out_valid=1. Moves to IDLE on out_valid && out_ready.
- On accept, the block registers x, y and sgn, clears the accumulator P (2*WIDTH bits) and sets i=0.
- Inputs are sampled only at accept. Changes to x, y or sgn afterwards are ignored.
- Iteration i, applied only when the x_reg[i] bit is set:
  - The addend is y_reg extended to 2*WIDTH bits, then shifted left by i. Extension is sign extension when sgn_reg=1 and zero extension when sgn_reg=0.
  - When sgn_reg=1 and i=WIDTH-1: P ← P − addend.
  - Otherwise: P ← P + addend.
  - All arithmetic is modulo 2^(2*WIDTH); carry and borrow out of the MSB are discarded.
  - When the x_reg[i] bit is clear, P is unchanged.
- z is driven from P. z is stable and equal to the final product for the whole DONE state.
- z is don't-care outside DONE, but must not glitch while out_valid=1.
- in_ready is low in BUSY and DONE, and in_valid is ignored in those states. The block has no overlap or bypass.
- out_valid is held until the handshake completes. The consumer may stall it indefinitely.
- Reset outputs: in_ready=0 during the reset cycle, then 1 in IDLE; out_valid=0; busy=0; z=0. Internal state: P=0, i=0, state IDLE.
- Reset asserted in BUSY or DONE abandons the operation and discards the result. No out_valid pulse is produced for it.
- rst has priority over any simultaneous handshake.

## Timing
- Accept at edge E0. BUSY covers edges E1..E_WIDTH. out_valid is high after edge E_WIDTH, i.e. WIDTH cycles after the accept edge.
- With out_ready held at 1:
  - DONE lasts 1 cycle.
  - IDLE lasts at least 1 cycle.
  - Minimum issue interval is WIDTH+2 cycles.
- busy is high for exactly WIDTH cycles per operation.
- The output path is registered only, with no combinational path from inputs to outputs.
- in_ready depends only on state and does not depend on in_valid.

## Test plan
- WIDTH=6, sgn=1, x=6'b110110 (−10), y=6'b101011 (−21) → z=12'h0D2 (210). out_valid rises exactly 6 cycles after the accept edge, and busy is high for 6 cycles.
- WIDTH=6, sgn=0, same operands (54×43) → z=12'h912 (2322). Check corners:
  - sgn=0, 63×63 → 12'hF81.
  - sgn=1, −32×−32 → 12'h400.
  - sgn=1, −32×31 → 12'hC20.
  - Either mode, x=0 or y=0 → 12'h000.
- Backpressure: hold out_ready=0 for 5 cycles in DONE. z and out_valid stay constant and in_ready stays 0. A toggling in_valid/x meanwhile causes no new accept.
- Reset mid-op: assert rst at iteration 3. Next cycle state is IDLE with out_valid=0, busy=0 and z=0. A following operation 7×5 unsigned gives 12'h023.
- Back-to-back: in_valid held high with changing operands and out_ready=1. Each operand set is accepted at WIDTH+2-cycle spacing, results arrive in order, and there are no drops or duplicates.
- Random regression at WIDTH=4, 6, 8 and 16, both modes, with random out_ready stalls: every z matches a reference product taken modulo 2^(2*WIDTH).
